// File: rtl/packet_pkg.sv
// packet_pkg: shared packet definitions for the packet_queue slice.
//   HDR_W_DEF / ADDR_W_DEF / DATA_W_DEF : default field widths
//   PKT_W                               : width of one stored packet word
//   pkt_t                               : packet struct at the default widths
//   pktWidth()                          : packet word width for arbitrary field widths
package packet_pkg;

  localparam int HDR_W_DEF  = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int PKT_W      = HDR_W_DEF + ADDR_W_DEF + DATA_W_DEF;

  typedef struct packed {
    logic [HDR_W_DEF-1:0]  header;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } pkt_t;

  function automatic int pktWidth(input int hdrW, input int addrW, input int dataW);
    return hdrW + addrW + dataW;
  endfunction

endpackage

// File: rtl/packet_queue_mem.sv
// packet_queue_mem: DEPTH x WIDTH register array, reset-free.
//   clock  : write clock
//   wrEn   : write strobe, wrData stored at wrAddr on the rising edge
//   rdAddr : asynchronous read address, rdData follows it combinationally
module packet_queue_mem
  import packet_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PKT_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/packet_queue.sv
// packet_queue: show-ahead packet FIFO with valid/ready on both sides.
//   clock, reset_n (sync, active-low), flush (sync clear)
//   inPacket_tx_*  : producer side (valid/ready + header/addr/data)
//   outPacket_rx_* : consumer side, head entry shown while valid
//   count          : occupied entries (registered)
// With FLOW=1 an empty queue forwards the tx packet combinationally to rx.
module packet_queue
  import packet_pkg::*;
#(
  parameter int HDR_W  = HDR_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int FLOW   = 0,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              inPacket_tx_valid,
  output logic              inPacket_tx_ready,
  input  logic [HDR_W-1:0]  inPacket_tx_header,
  input  logic [ADDR_W-1:0] inPacket_tx_addr,
  input  logic [DATA_W-1:0] inPacket_tx_data,
  output logic              outPacket_rx_valid,
  input  logic              outPacket_rx_ready,
  output logic [HDR_W-1:0]  outPacket_rx_header,
  output logic [ADDR_W-1:0] outPacket_rx_addr,
  output logic [DATA_W-1:0] outPacket_rx_data,
  output logic [CW-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = pktWidth(HDR_W, ADDR_W, DATA_W);

  typedef struct packed {
    logic [HDR_W-1:0]  header;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entryT;

  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] cnt;
  logic          full, empty, bypass, enq, deq, passThru, wrEn, rdEn;
  entryT         txPkt, memPkt, rxPkt;
  logic [PW-1:0] memRd;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Ready is held low in reset; otherwise it depends only on registered occupancy.
  assign inPacket_tx_ready = reset_n & ~full;

  assign bypass = (FLOW != 0) && empty && reset_n;
  assign outPacket_rx_valid = bypass ? inPacket_tx_valid : ~empty;

  assign enq = inPacket_tx_valid & inPacket_tx_ready;
  assign deq = outPacket_rx_valid & outPacket_rx_ready;

  // A bypassed packet consumed in the same cycle never touches storage.
  assign passThru = bypass & enq & deq;
  assign wrEn     = enq & ~passThru & ~flush;
  assign rdEn     = deq & ~empty & ~flush;

  assign txPkt  = {inPacket_tx_header, inPacket_tx_addr, inPacket_tx_data};
  assign memPkt = entryT'(memRd);
  assign rxPkt  = bypass ? txPkt : memPkt;

  assign outPacket_rx_header = rxPkt.header;
  assign outPacket_rx_addr   = rxPkt.addr;
  assign outPacket_rx_data   = rxPkt.data;
  assign count               = cnt;

  packet_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) uMem (
    .clock  (clock),
    .wrEn   (wrEn),
    .wrAddr (wrPtr),
    .wrData (PW'(txPkt)),
    .rdAddr (rdPtr),
    .rdData (memRd)
  );

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + AW'(1);
      if (rdEn) rdPtr <= rdPtr + AW'(1);
      if (wrEn && !rdEn)      cnt <= cnt + CW'(1);
      else if (rdEn && !wrEn) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_packet_queue.sv
module tb_packet_queue;
  import packet_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, flush, txValid, rxReady;
  logic [15:0] txHdr, txAddr;
  logic [31:0] txData;

  logic [1:0]  txReadyA, rxValidA;
  logic [15:0] rxHdr  [2];
  logic [15:0] rxAddr [2];
  logic [31:0] rxData [2];
  logic [2:0]  cntA   [2];

  int nChecks = 0;
  int nFail   = 0;

  packet_queue #(.DEPTH(4), .FLOW(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .inPacket_tx_valid(txValid), .inPacket_tx_ready(txReadyA[0]),
    .inPacket_tx_header(txHdr), .inPacket_tx_addr(txAddr), .inPacket_tx_data(txData),
    .outPacket_rx_valid(rxValidA[0]), .outPacket_rx_ready(rxReady),
    .outPacket_rx_header(rxHdr[0]), .outPacket_rx_addr(rxAddr[0]), .outPacket_rx_data(rxData[0]),
    .count(cntA[0])
  );

  packet_queue #(.DEPTH(4), .FLOW(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .inPacket_tx_valid(txValid), .inPacket_tx_ready(txReadyA[1]),
    .inPacket_tx_header(txHdr), .inPacket_tx_addr(txAddr), .inPacket_tx_data(txData),
    .outPacket_rx_valid(rxValidA[1]), .outPacket_rx_ready(rxReady),
    .outPacket_rx_header(rxHdr[1]), .outPacket_rx_addr(rxAddr[1]), .outPacket_rx_data(rxData[1]),
    .count(cntA[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one plain packet queue per instance.
  pkt_t mq0[$];
  pkt_t mq1[$];

  function automatic int qSize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic pkt_t qFront(input int k);
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic qPush(input int k, input pkt_t p);
    if (k == 0) mq0.push_back(p); else mq1.push_back(p);
  endtask

  task automatic qPop(input int k);
    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
  endtask

  task automatic qClear(input int k);
    if (k == 0) mq0.delete(); else mq1.delete();
  endtask

  // Compare, then advance the model with the inputs seen by the coming edge.
  always @(negedge clock) begin
    int   sz;
    bit   byp, ev, er, enq, deq;
    pkt_t e, tp;
    tp = '{header: txHdr, addr: txAddr, data: txData};
    for (int k = 0; k < 2; k++) begin
      sz  = qSize(k);
      byp = (k == 1) && (sz == 0) && reset_n;
      ev  = byp ? txValid : (sz > 0);
      er  = reset_n && (sz < 4);
      chk($sformatf("d%0d_count", k), 64'(cntA[k]), 64'(sz));
      chk($sformatf("d%0d_txReady", k), 64'(txReadyA[k]), 64'(er));
      chk($sformatf("d%0d_rxValid", k), 64'(rxValidA[k]), 64'(ev));
      if (ev) begin
        e = byp ? tp : qFront(k);
        chk($sformatf("d%0d_rxHeader", k), 64'(rxHdr[k]), 64'(e.header));
        chk($sformatf("d%0d_rxAddr", k), 64'(rxAddr[k]), 64'(e.addr));
        chk($sformatf("d%0d_rxData", k), 64'(rxData[k]), 64'(e.data));
      end
      if (!reset_n || flush) begin
        qClear(k);
      end else begin
        enq = txValid && er;
        deq = ev && rxReady;
        if (!(byp && enq && deq)) begin
          if (deq) qPop(k);
          if (enq) qPush(k, tp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] h, input logic [15:0] a, input logic [31:0] d);
    txValid = v;
    txHdr   = h;
    txAddr  = a;
    txData  = d;
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    rxReady = 1'b0;
    drive(1'b1, 16'h0, 16'h0, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_txReady", 64'(txReadyA[0]), 64'd0);
    chk("rst_rxValid", 64'(rxValidA[0]), 64'd0);
    chk("rst_rxValidFlow", 64'(rxValidA[1]), 64'd0);
    chk("rst_count", 64'(cntA[0]), 64'd0);

    reset_n = 1'b1;
    txValid = 1'b0;
    step();
    chk("rel_txReady", 64'(txReadyA[0]), 64'd1);

    // Fill with consumer stalled.
    for (int h = 1; h <= 4; h++) begin
      drive(1'b1, 16'(h), 16'(h * 16), 32'(h * 256));
      step();
    end
    txValid = 1'b0;
    #1;
    chk("fill_count", 64'(cntA[0]), 64'd4);
    chk("fill_txReady", 64'(txReadyA[0]), 64'd0);

    // Full: offered packet refused while head is consumed.
    drive(1'b1, 16'd5, 16'd80, 32'd1280);
    rxReady = 1'b1;
    #1;
    chk("full_head", 64'(rxHdr[0]), 64'd1);
    step();
    chk("full_deq_count", 64'(cntA[0]), 64'd3);
    chk("full_deq_txReady", 64'(txReadyA[0]), 64'd1);
    rxReady = 1'b0;
    step();
    chk("fifth_count", 64'(cntA[0]), 64'd4);

    txValid = 1'b0;
    rxReady = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      #1;
      chk("drain_valid", 64'(rxValidA[0]), 64'd1);
      chk("drain_header", 64'(rxHdr[0]), 64'(e));
      chk("drain_addr", 64'(rxAddr[0]), 64'(e * 16));
      chk("drain_data", 64'(rxData[0]), 64'(e * 256));
      step();
    end
    chk("drain_count", 64'(cntA[0]), 64'd0);

    // Streaming, both sides ready.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 16'(i), 16'(i + 100), 32'(i));
      #1;
      if (i > 0) chk("stream_data", 64'(rxData[0]), 64'(i - 1));
      step();
      chk("stream_count", 64'(cntA[0]), 64'd1);
      chk("stream_countFlow", 64'(cntA[1]), 64'd0);
    end
    txValid = 1'b0;
    step();

    // Flush with simultaneous enqueue.
    rxReady = 1'b0;
    for (int h = 16; h < 19; h++) begin
      drive(1'b1, 16'(h), 16'(h), 32'(h));
      step();
    end
    drive(1'b1, 16'h99, 16'h99, 32'h99);
    flush = 1'b1;
    #1;
    chk("preflush_count", 64'(cntA[0]), 64'd3);
    step();
    flush   = 1'b0;
    txValid = 1'b0;
    #1;
    chk("flush_count", 64'(cntA[0]), 64'd0);
    chk("flush_rxValid", 64'(rxValidA[0]), 64'd0);
    rxReady = 1'b1;
    repeat (3) step();

    // Flow-through on the empty FLOW=1 queue.
    drive(1'b1, 16'hABCD, 16'h1234, 32'hDEADBEEF);
    rxReady = 1'b1;
    #1;
    chk("flow_rxValid", 64'(rxValidA[1]), 64'd1);
    chk("flow_header", 64'(rxHdr[1]), 64'hABCD);
    chk("flow_addr", 64'(rxAddr[1]), 64'h1234);
    chk("flow_data", 64'(rxData[1]), 64'hDEADBEEF);
    step();
    chk("flow_count", 64'(cntA[1]), 64'd0);
    rxReady = 1'b0;
    step();
    chk("flow_stored_count", 64'(cntA[1]), 64'd1);
    txValid = 1'b0;
    flush   = 1'b1;
    step();
    flush = 1'b0;

    // Randomised traffic with varying pressure on each side.
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase   = (i / 250) % 4;
      reset_n = ($urandom_range(0, 199) != 0);
      flush   = ($urandom_range(0, 47) == 0);
      txValid = (phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rxReady = (phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      txHdr   = 16'($urandom);
      txAddr  = 16'($urandom);
      txData  = $urandom;
      step();
    end
    reset_n = 1'b1;
    flush   = 1'b0;
    txValid = 1'b0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
